// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants and types for the V3023 RTC read sequencer.
// Holds bus timing defaults, register addresses, the sequencer state encoding,
// the bus phase kinds and the index-to-address map.
// Optional feature macro: RTC_RD_TIMER_EN (adds timer registers 0x41-0x43).
package rtc_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 4;

  // Bus timing in clock cycles.
  localparam int unsigned T_SU  = 2;
  localparam int unsigned T_PW  = 8;
  localparam int unsigned T_HD  = 2;
  localparam int unsigned T_GAP = 4;

  localparam int unsigned PH_LEN = T_SU + T_PW + T_HD;
  localparam int unsigned PH_MAX = (PH_LEN > T_GAP) ? PH_LEN : T_GAP;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

`ifdef RTC_RD_TIMER_EN
  localparam int unsigned N_REGS = 9;
`else
  localparam int unsigned N_REGS = 6;
`endif

  // RTC register addresses.
  localparam logic [BYTE_W-1:0] ADDR_CMD      = 8'hF0;
  localparam logic [BYTE_W-1:0] ADDR_SEG      = 8'h21;
  localparam logic [BYTE_W-1:0] ADDR_MIN      = 8'h22;
  localparam logic [BYTE_W-1:0] ADDR_HORA     = 8'h23;
  localparam logic [BYTE_W-1:0] ADDR_DIA      = 8'h24;
  localparam logic [BYTE_W-1:0] ADDR_MES      = 8'h25;
  localparam logic [BYTE_W-1:0] ADDR_ANIO     = 8'h26;
  localparam logic [BYTE_W-1:0] ADDR_SEG_TIM  = 8'h41;
  localparam logic [BYTE_W-1:0] ADDR_MIN_TIM  = 8'h42;
  localparam logic [BYTE_W-1:0] ADDR_HORA_TIM = 8'h43;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA    = 3'd3,
    ST_PUBLISH = 3'd4
  } seq_state_e;

  typedef enum logic {
    PH_ADDR_WR = 1'b0,
    PH_DATA_RD = 1'b1
  } phase_kind_e;

  // Register address for a shadow-bank index.
  function automatic logic [BYTE_W-1:0] reg_addr(input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_W'(0): return ADDR_SEG;
      IDX_W'(1): return ADDR_MIN;
      IDX_W'(2): return ADDR_HORA;
      IDX_W'(3): return ADDR_DIA;
      IDX_W'(4): return ADDR_MES;
      IDX_W'(5): return ADDR_ANIO;
      IDX_W'(6): return ADDR_SEG_TIM;
      IDX_W'(7): return ADDR_MIN_TIM;
      IDX_W'(8): return ADDR_HORA_TIM;
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_phase.sv
// rtc_bus_phase: drives one bus phase (address write or data read) followed by
// the inter-phase gap, with setup / strobe / hold / gap timing.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   go, kind, addr      start a phase; accepted when idle or in the last gap cycle
//   bus_out, bus_oe     address byte and its drive enable
//   a_d, cs, rd, wr     bus control (cs/rd/wr active-low)
//   sample              high during the last rd-low cycle of a data phase
//   phase_done          high during the last gap cycle
// Optional feature macro: none here (RTC_RD_TIMER_EN lives in the sequencer).
module rtc_bus_phase
  import rtc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  phase_kind_e       kind,
  input  logic [BYTE_W-1:0] addr,
  output logic [BYTE_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              a_d,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic              sample,
  output logic              phase_done
);

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_ACT  = 2'd1,
    PS_GAP  = 2'd2
  } ph_state_e;

  ph_state_e         st_q, st_d;
  logic [PH_W-1:0]   cnt_q, cnt_d;
  phase_kind_e       kind_q, kind_d;
  logic [BYTE_W-1:0] addr_q, addr_d;

  logic [BYTE_W-1:0] bus_out_q, bus_out_d;
  logic              bus_oe_q, bus_oe_d;
  logic              a_d_q, a_d_d;
  logic              cs_q, cs_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              sample_q, sample_d;
  logic              phase_done_q, phase_done_d;
  logic              strobe_win_c;

  // Phase position: active window, then gap; a new go in the last gap cycle
  // chains phases without an idle cycle.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    addr_d = addr_q;
    unique case (st_q)
      PS_IDLE: begin
        if (go) begin
          st_d   = PS_ACT;
          cnt_d  = '0;
          kind_d = kind;
          addr_d = addr;
        end
      end
      PS_ACT: begin
        if (cnt_q == PH_W'(PH_LEN - 1)) begin
          st_d  = PS_GAP;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      PS_GAP: begin
        if (cnt_q == PH_W'(T_GAP - 1)) begin
          cnt_d = '0;
          if (go) begin
            st_d   = PS_ACT;
            kind_d = kind;
            addr_d = addr;
          end else begin
            st_d = PS_IDLE;
          end
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      default: begin
        st_d  = PS_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Pad values decoded from the next position so they register alongside it.
  always_comb begin
    bus_out_d    = '0;
    bus_oe_d     = 1'b0;
    a_d_d        = 1'b1;
    cs_d         = 1'b1;
    rd_d         = 1'b1;
    wr_d         = 1'b1;
    sample_d     = 1'b0;
    phase_done_d = 1'b0;
    strobe_win_c = (cnt_d >= PH_W'(T_SU)) && (cnt_d < PH_W'(T_SU + T_PW));
    if (st_d == PS_ACT) begin
      cs_d = 1'b0;
      if (kind_d == PH_ADDR_WR) begin
        a_d_d     = 1'b0;
        bus_oe_d  = 1'b1;
        bus_out_d = addr_d;
        wr_d      = !strobe_win_c;
      end else begin
        rd_d     = !strobe_win_c;
        sample_d = (cnt_d == PH_W'(T_SU + T_PW - 1));
      end
    end
    if ((st_d == PS_GAP) && (cnt_d == PH_W'(T_GAP - 1))) begin
      phase_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q         <= PS_IDLE;
      cnt_q        <= '0;
      kind_q       <= PH_ADDR_WR;
      addr_q       <= '0;
      bus_out_q    <= '0;
      bus_oe_q     <= 1'b0;
      a_d_q        <= 1'b1;
      cs_q         <= 1'b1;
      rd_q         <= 1'b1;
      wr_q         <= 1'b1;
      sample_q     <= 1'b0;
      phase_done_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      kind_q       <= kind_d;
      addr_q       <= addr_d;
      bus_out_q    <= bus_out_d;
      bus_oe_q     <= bus_oe_d;
      a_d_q        <= a_d_d;
      cs_q         <= cs_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      sample_q     <= sample_d;
      phase_done_q <= phase_done_d;
    end
  end

  assign bus_out    = bus_out_q;
  assign bus_oe     = bus_oe_q;
  assign a_d        = a_d_q;
  assign cs         = cs_q;
  assign rd         = rd_q;
  assign wr         = wr_q;
  assign sample     = sample_q;
  assign phase_done = phase_done_q;

endmodule

// File: rtl/rtc_read_seq.sv
// rtc_read_seq: read-side sequencer for the V3023 RTC. On start it issues the
// 0xF0 transfer command, reads each date/time(/timer) register into a shadow
// bank, then publishes the whole bank to the outputs in one cycle with done.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   start                             burst request, sampled only when idle
//   bus_in                            data from the RTC bus pad
//   bus_out, bus_oe, a_d, cs, rd, wr  RTC bus drive (cs/rd/wr active-low)
//   busy, done                        burst in progress / one-cycle publish pulse
//   seg..anio, seg_tim..hora_tim      published BCD values
// Optional feature macro: RTC_RD_TIMER_EN reads 0x41-0x43 into the timer
// outputs; without it those outputs are tied to 0x00.
module rtc_read_seq
  import rtc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] bus_in,
  output logic [BYTE_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              a_d,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] seg,
  output logic [BYTE_W-1:0] min,
  output logic [BYTE_W-1:0] hora,
  output logic [BYTE_W-1:0] dia,
  output logic [BYTE_W-1:0] mes,
  output logic [BYTE_W-1:0] anio,
  output logic [BYTE_W-1:0] seg_tim,
  output logic [BYTE_W-1:0] min_tim,
  output logic [BYTE_W-1:0] hora_tim
);

  seq_state_e                     state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic [N_REGS-1:0][BYTE_W-1:0]  shadow_q, shadow_d;
  logic [N_REGS-1:0][BYTE_W-1:0]  out_q, out_d;

  logic                           go_c;
  phase_kind_e                    kind_c;
  logic [BYTE_W-1:0]              addr_c;
  logic                           sample;
  logic                           phase_done;

  rtc_bus_phase u_phase (
    .clk        (clk),
    .reset      (reset),
    .go         (go_c),
    .kind       (kind_c),
    .addr       (addr_c),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .a_d        (a_d),
    .cs         (cs),
    .rd         (rd),
    .wr         (wr),
    .sample     (sample),
    .phase_done (phase_done)
  );

  // Sequencing: the next phase is requested in the last gap cycle of the
  // current one so the phase engine chains them back to back.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    shadow_d = shadow_q;
    out_d    = out_q;
    go_c     = 1'b0;
    kind_c   = PH_ADDR_WR;
    addr_c   = ADDR_CMD;

    if (sample) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          shadow_d[i] = bus_in;
        end
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          go_c    = 1'b1;
          state_d = ST_CMD;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_CMD: begin
        if (phase_done) begin
          go_c    = 1'b1;
          addr_c  = reg_addr(idx_q);
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (phase_done) begin
          go_c    = 1'b1;
          kind_c  = PH_DATA_RD;
          addr_c  = reg_addr(idx_q);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (phase_done) begin
          if (idx_q == IDX_W'(N_REGS - 1)) begin
            state_d = ST_PUBLISH;
            out_d   = shadow_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            go_c    = 1'b1;
            addr_c  = reg_addr(idx_d);
            state_d = ST_ADDR;
          end
        end
      end
      ST_PUBLISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shadow_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign seg  = out_q[0];
  assign min  = out_q[1];
  assign hora = out_q[2];
  assign dia  = out_q[3];
  assign mes  = out_q[4];
  assign anio = out_q[5];

`ifdef RTC_RD_TIMER_EN
  assign seg_tim  = out_q[6];
  assign min_tim  = out_q[7];
  assign hora_tim = out_q[8];
`else
  assign seg_tim  = '0;
  assign min_tim  = '0;
  assign hora_tim = '0;
`endif

endmodule

// File: tb/tb_rtc_read_seq.sv
// tb_rtc_read_seq: randomized bench for rtc_read_seq with an RTC bus model,
// a bus-protocol monitor and an address/data reference built from the
// register map. Honors RTC_RD_TIMER_EN the same way as the design.
module tb_rtc_read_seq;

`ifdef RTC_RD_TIMER_EN
  localparam int N_REG = 9;
`else
  localparam int N_REG = 6;
`endif
  localparam int PHASE_CYC = 2 + 8 + 2;
  localparam int GAP_CYC   = 4;
  localparam int BURST_L   = (PHASE_CYC + GAP_CYC) * (1 + 2 * N_REG);

  logic       clk, reset, start;
  logic [7:0] bus_in, bus_out;
  logic       bus_oe, a_d, cs, rd, wr, busy, done;
  logic [7:0] seg, min, hora, dia, mes, anio, seg_tim, min_tim, hora_tim;

  rtc_read_seq dut (
    .clk(clk), .reset(reset), .start(start), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .busy(busy), .done(done),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .seg_tim(seg_tim), .min_tim(min_tim), .hora_tim(hora_tim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RTC model: address latched during a wr-low address phase, data driven while rd low.
  logic [7:0] rtc_mem [256];
  logic [7:0] lat_addr;
  assign bus_in = (!rd) ? rtc_mem[lat_addr] : 8'hA5;

  int n_checks, n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus address for transaction i of a burst: command, then the register list.
  function automatic logic [7:0] exp_addr(input int i);
    if (i == 0) return 8'hF0;
    if (i <= 6) return 8'(32'h20 + i);
    return 8'(32'h41 + (i - 7));
  endfunction

  function automatic logic [7:0] out_at(input int r);
    case (r)
      0: return seg;     1: return min;     2: return hora;
      3: return dia;     4: return mes;     5: return anio;
      6: return seg_tim; 7: return min_tim; 8: return hora_tim;
      default: return 8'h00;
    endcase
  endfunction

  // Protocol monitor
  int v_overlap, v_cs_strobe, v_idle_bus, v_hold, v_kind, v_pos, v_slen, v_clen, v_gap;
  int cs_run, wr_run, rd_run, hi_run, n_rd;
  bit hi_busy, cs_prev, wr_prev, rd_prev, ph_ad;
  logic [7:0] ph_addr;
  logic [7:0] addr_log [$];

  initial begin
    v_overlap = 0; v_cs_strobe = 0; v_idle_bus = 0; v_hold = 0; v_kind = 0;
    v_pos = 0; v_slen = 0; v_clen = 0; v_gap = 0; n_rd = 0;
    cs_run = 0; wr_run = 0; rd_run = 0; hi_run = 0; hi_busy = 0;
    cs_prev = 1; wr_prev = 1; rd_prev = 1; ph_ad = 1; ph_addr = 8'h00; lat_addr = 8'h00;
  end

  always @(negedge clk) begin
    if (reset) begin
      cs_prev = 1; wr_prev = 1; rd_prev = 1;
      cs_run = 0; wr_run = 0; rd_run = 0; hi_run = 0; hi_busy = 0;
    end else begin
      if (!rd && !wr) v_overlap++;
      if (cs && (!rd || !wr)) v_cs_strobe++;
      if (cs && (bus_oe || !a_d)) v_idle_bus++;
      if (!cs && cs_prev) begin
        if (hi_busy && hi_run != GAP_CYC) v_gap++;
        cs_run = 0; ph_addr = bus_out; ph_ad = a_d;
      end
      if (!cs) begin
        if (a_d != ph_ad) v_hold++;
        if (!a_d && (!bus_oe || bus_out != ph_addr)) v_hold++;
        if (a_d && bus_oe) v_hold++;
        if ((!a_d && !rd) || (a_d && !wr)) v_kind++;
        if (!a_d && !wr) lat_addr = bus_out;
      end
      if (!wr && wr_prev) begin
        if (cs_run != 2) v_pos++;
        addr_log.push_back(bus_out);
        wr_run = 0;
      end
      if (!rd && rd_prev) begin
        if (cs_run != 2) v_pos++;
        n_rd++;
        rd_run = 0;
      end
      if (wr && !wr_prev && wr_run != 8) v_slen++;
      if (rd && !rd_prev && rd_run != 8) v_slen++;
      if (cs && !cs_prev) begin
        if (cs_run != PHASE_CYC) v_clen++;
        hi_run = 0; hi_busy = 1;
      end
      if (!wr) wr_run++;
      if (!rd) rd_run++;
      if (!cs) cs_run++;
      else begin
        hi_run++;
        hi_busy = hi_busy && busy;
      end
      cs_prev = cs; wr_prev = wr; rd_prev = rd;
    end
  end

  logic [7:0] prev_out [9];

  task automatic load_mem(input logic [7:0] v0, input logic [7:0] step, input bit rnd);
    for (int r = 0; r < 9; r++)
      rtc_mem[exp_addr(r + 1)] = rnd ? 8'($urandom_range(0, 255)) : 8'(v0 + 8'(r) * step);
  endtask

  // One burst: start sampled at the next rising edge E; done expected in cycle E+1+L.
  task automatic run_burst(input string tag, input int restart_at, input bit keep_start);
    int k, v_pub, v_busy;
    bit seen;
    logic [7:0] expv [9];
    for (int r = 0; r < 9; r++) expv[r] = (r < N_REG) ? rtc_mem[exp_addr(r + 1)] : 8'h00;
    addr_log.delete();
    n_rd = 0;
    start = 1'b1;
    @(posedge clk);
    k = 0; seen = 0; v_pub = 0; v_busy = 0;
    while (!seen && k < BURST_L + 20) begin
      @(negedge clk);
      k++;
      if (!keep_start) start = (k == restart_at);
      if (k == 1) check($sformatf("%s busy_rise", tag), busy, 1'b1);
      if (done) seen = 1;
      else begin
        if (!busy) v_busy++;
        for (int r = 0; r < 9; r++) if (out_at(r) !== prev_out[r]) v_pub++;
      end
    end
    check($sformatf("%s done_cycle", tag), seen ? k : 0, BURST_L + 1);
    check($sformatf("%s busy_at_done", tag), busy, 1'b0);
    check($sformatf("%s busy_gaps", tag), v_busy, 0);
    check($sformatf("%s early_update", tag), v_pub, 0);
    for (int r = 0; r < 9; r++) begin
      check($sformatf("%s out%0d", tag, r), out_at(r), expv[r]);
      prev_out[r] = expv[r];
    end
    check($sformatf("%s addr_count", tag), addr_log.size(), N_REG + 1);
    for (int i = 0; i < N_REG + 1 && i < addr_log.size(); i++)
      check($sformatf("%s addr%0d", tag, i), addr_log[i], exp_addr(i));
    check($sformatf("%s rd_count", tag), n_rd, N_REG);
    @(negedge clk);
    check($sformatf("%s done_pulse", tag), done, 1'b0);
    check($sformatf("%s idle_busy", tag), busy, 1'b0);
  endtask

  initial begin
    int n_done;
    n_checks = 0; n_errors = 0;
    reset = 1'b1; start = 1'b0;
    for (int a = 0; a < 256; a++) rtc_mem[a] = 8'hEE;
    for (int r = 0; r < 9; r++) prev_out[r] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst cs", cs, 1'b1);
    check("rst rd", rd, 1'b1);
    check("rst wr", wr, 1'b1);
    check("rst a_d", a_d, 1'b1);
    check("rst bus_oe", bus_oe, 1'b0);
    check("rst bus_out", bus_out, 8'h00);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    for (int r = 0; r < 9; r++) check($sformatf("rst out%0d", r), out_at(r), 8'h00);
    #2 reset = 1'b0;
    @(negedge clk);

    rtc_mem[8'h21] = 8'h59; rtc_mem[8'h22] = 8'h30; rtc_mem[8'h23] = 8'h12;
    rtc_mem[8'h24] = 8'h15; rtc_mem[8'h25] = 8'h08; rtc_mem[8'h26] = 8'h16;
    rtc_mem[8'h41] = 8'h05; rtc_mem[8'h42] = 8'h04; rtc_mem[8'h43] = 8'h03;
    run_burst("single", 0, 1'b0);

    load_mem(8'h11, 8'h01, 1'b0);
    run_burst("atomic", 0, 1'b0);

    load_mem(8'h00, 8'h00, 1'b1);
    run_burst("start_busy", 50, 1'b0);

    load_mem(8'h00, 8'h00, 1'b1);
    run_burst("b2b_a", 0, 1'b1);
    load_mem(8'h00, 8'h00, 1'b1);
    run_burst("b2b_b", 0, 1'b0);

    // Reset in the middle of a data-phase rd-low window.
    load_mem(8'h00, 8'h00, 1'b1);
    n_done = 0;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) n_done++;
    end
    check("rst_mid rd_before", rd, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_mid rd_async", rd, 1'b1);
    check("rst_mid cs_async", cs, 1'b1);
    check("rst_mid wr_async", wr, 1'b1);
    check("rst_mid busy", busy, 1'b0);
    for (int r = 0; r < 9; r++) check($sformatf("rst_mid out%0d", r), out_at(r), 8'h00);
    for (int r = 0; r < 9; r++) prev_out[r] = 8'h00;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    #2 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("rst_mid no_done", n_done, 0);
    check("rst_mid seg_after", seg, 8'h00);

    load_mem(8'h00, 8'h00, 1'b1);
    run_burst("after_rst", 0, 1'b0);
    for (int b = 0; b < 2; b++) begin
      load_mem(8'h00, 8'h00, 1'b1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_burst($sformatf("rand%0d", b), 0, 1'b0);
    end

    check("mon rd_wr_overlap", v_overlap, 0);
    check("mon strobe_cs_high", v_cs_strobe, 0);
    check("mon gap_bus", v_idle_bus, 0);
    check("mon phase_hold", v_hold, 0);
    check("mon strobe_kind", v_kind, 0);
    check("mon strobe_start", v_pos, 0);
    check("mon strobe_len", v_slen, 0);
    check("mon cs_len", v_clen, 0);
    check("mon gap_len", v_gap, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rtc_read_seq.md
Name: rtc_read_seq

Overview:
- Read-side sequencer for the V3023-style RTC on the multiplexed 8-bit bus (a_d, cs, rd, wr; all active-low).
- On `start`, it first issues the 0xF0 "transfer to RAM" command address. It then reads the date, time and timer registers in a fixed order into a shadow bank.
- The shadow bank is published to the output registers in one step, together with a `done` pulse.
- Counterpart of the RTC write sequencer. The top-level controller uses it to refresh the displayed time/date.

Parameters:
- T_SU, 2, cycles with cs low and bus stable before the strobe falls.
- T_PW, 8, strobe-low cycles (wr or rd).
- T_HD, 2, cycles with cs low and bus held after the strobe rises.
- T_GAP, 4, cycles with cs high after each phase.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  request a full read burst (level or pulse)
- bus_in  in  8  data from the RTC bus pad
- bus_out  out  8  address driven onto the bus
- bus_oe  out  1  bus_out drive enable
- a_d  out  1  0 = address phase, 1 = data phase
- cs  out  1  chip select, active-low
- rd  out  1  read strobe, active-low
- wr  out  1  write strobe, active-low
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when the output bank has been updated
- seg, min, hora, dia, mes, anio  out  8 each  BCD time/date
- seg_tim, min_tim, hora_tim  out  8 each  BCD timer

Interface (already decided): reset `reset`, asynchronous, active-high; clock `clk`.

Behaviour:
- **Reset values:**
  - cs=rd=wr=a_d=1; bus_oe=0; bus_out=0x00.
  - busy=0; done=0; all data outputs and shadow registers = 0x00; FSM in IDLE.
- **Top FSM:** IDLE -> CMD -> (ADDR -> DATA) per register -> PUBLISH -> IDLE.
- **Register list**, index 0..N-1:
  - 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 anio.
  - Then 0x41 seg_tim, 0x42 min_tim, 0x43 hora_tim (see Optional Feature).
- **Start:**
  - `start` is sampled only in IDLE. If start=1 at edge E, busy=1 from the cycle after E.
  - `start` is ignored while busy=1; it is not queued.
- **Address phase (CMD and ADDR):**
  - a_d=0, bus_oe=1, bus_out=address, cs=0 for T_SU+T_PW+T_HD cycles.
  - wr=0 during the middle T_PW cycles; rd=1 throughout.
  - CMD uses address 0xF0 and is followed by no data phase.
- **Data phase (DATA):**
  - a_d=1, bus_oe=0, cs=0 for T_SU+T_PW+T_HD cycles.
  - rd=0 during the middle T_PW cycles; wr=1 throughout.
  - bus_in is captured into shadow[index] at the clock edge that ends the last rd-low cycle.
- **Gap:** every phase is followed by T_GAP cycles with cs=rd=wr=1, bus_oe=0, a_d=1.
- **Strobe ordering:**
  - rd and wr are never low simultaneously.
  - A strobe is never low while cs=1.
  - a_d and bus_oe change only while cs=1 or during T_SU/T_HD, never while a strobe is low.
- **Burst length** (defaults: phase = 12 cycles, gap = 4):
  - Command = 16 cycles; each register = 32 cycles.
  - Total L = 16 + 32·N, giving 208 cycles for N=6 and 304 cycles for N=9.
- **PUBLISH:**
  - One cycle: all shadow registers are copied to the outputs, done=1, busy=0.
  - done=1 falls in cycle E+1+L.
  - Outputs are never partially updated mid-burst.
- **Counters:**
  - Phase counter wide enough for max(T_SU+T_PW+T_HD, T_GAP); it wraps to 0 at the end of each phase.
  - Index counter is 4-bit; it ends at N-1, never past it.
- **Reset mid-burst:**
  - Immediate return to the reset values. Strobes go high asynchronously.
  - Outputs and shadow registers are cleared; no done pulse.
- **Back-to-back:** if start is held, the next burst begins in the cycle after the done cycle (IDLE lasts one cycle).

Optional Feature:
- Macro: RTC_RD_TIMER_EN.
- Defined: N=9; timer registers 0x41-0x43 are read; L=304 at default timing.
- Undefined:
  - N=6; L=208 at default timing.
  - seg_tim, min_tim and hora_tim stay 0x00 permanently.
  - No accesses to 0x41-0x43 appear on the bus.

Decomposition:
- Package rtc_pkg:
  - Register address constants: 0xF0 command; 0x21-0x26; 0x41-0x43.
  - Default timing constants.
  - Top-FSM state encoding.
  - Phase-kind encoding (ADDR_WR / DATA_RD).
- Sub-module rtc_bus_phase:
  - Inputs: go, kind, address. Outputs: cs/rd/wr/a_d/bus_oe/bus_out, sample pulse, phase_done.
  - Implements SU/PW/HD/GAP timing.
  - rtc_read_seq holds only the sequencing, the index and the shadow/output registers.

Test Plan:
- **Single burst:** reset, then start pulse with a bus model returning 0x59, 0x30, 0x12, 0x15, 0x08, 0x16 (plus 0x05, 0x04, 0x03 with the timer macro) -> outputs match exactly; done is one pulse at E+1+208 (E+1+304 with macro); busy high in between.
- **Bus timing:** monitor the 0xF0 and 0x21 address phases -> bus_out=0xF0 then 0x21 held with bus_oe=1 for 12 cycles; wr low for exactly 8 cycles starting 2 cycles after cs falls; never rd&wr low together; cs high 4 cycles between phases.
- **Atomic publish:** bus model returns 0x11..0x19 -> seg stays 0x00 until the done cycle, then all outputs change in the same cycle.
- **Start while busy:** pulse start again at cycle E+50 -> no restart; exactly one done pulse; the sequence of addresses on the bus is unchanged.
- **Reset mid-burst:** assert reset at cycle E+100 (during an rd-low) -> rd/cs go to 1 without waiting for a clock edge; outputs 0x00; no done; a new start after release gives a full correct burst.
- **Macro off:** build without RTC_RD_TIMER_EN -> no 0x41-0x43 accesses on the bus; done at E+1+208; seg_tim/min_tim/hora_tim remain 0x00.
